ball_hit_resolver: RTL and testbench
====================================

# ball_hit_resolver

Downstream consumer of the player projectile stage. Each frame it checks the live projectile against the opposing fighter's hitbox and applies at most one hit per projectile flight. It also tracks the target's health, an invulnerability window and a knock-out state. On a hit it pulses `ball_clear` back to the projectile stage and raises hit, knockback and HP information for the HUD and fighter logic.

## Interface
Parameters:
- `BALL_W`, default 16: projectile hitbox width, pixels
- `BALL_H`, default 16: projectile hitbox height, pixels
- `TGT_W`, default 40: target hitbox width, pixels
- `TGT_H`, default 80: target hitbox height, pixels
- `DAMAGE`, default 10: HP removed per hit, 1..127
- `MAX_HP`, default 100: HP at reset and at round start, 1..127
- `INVULN_FRAMES`, default 30: frames of invulnerability after a non-fatal hit, 1..63

Ports:
- `frame_clk`  in  1: the only clock, one edge per video frame
- `Reset`  in  1: synchronous, active-high
- `summoned_ball`  in  1: projectile in flight
- `ball_x`, `ball_y`  in  10 each: projectile top-left, pixels
- `ball_face`  in  1: projectile direction; 0 = moving right, 1 = moving left
- `target_x`, `target_y`  in  10 each: target hitbox top-left, pixels
- `round_start`  in  1: restore the target for a new round
- `ball_clear`  out  1: one-frame pulse asking the projectile stage to despawn
- `hit`  out  1: one-frame pulse on each accepted hit
- `knockback_dir`  out  1: `ball_face` captured on the last accepted hit
- `target_hp`  out  7: current HP
- `invuln`  out  1: high while in state INVULN
- `ko`  out  1: high while in state KO

## Operation
- Overlap is combinational and computed in 11-bit unsigned arithmetic, so there is no wrap at the 10-bit edge.
  - Condition: `ball_x < target_x+TGT_W`, `target_x < ball_x+BALL_W`, `ball_y < target_y+TGT_H`, `target_y < ball_y+BALL_H`.
  - All four comparisons are strict, so boxes that only touch edges do not overlap.
- `spent` flag:
  - Set when a hit is accepted.
  - Cleared on any frame where `summoned_ball`=0.
  - This gives one hit per flight.
- `candidate` = `summoned_ball` & ~`spent` & overlap.
- State machine with states ALIVE, INVULN, KO:
  - **ALIVE:** on `candidate`, accept a hit.
    - `hp` <= `hp`>`DAMAGE` ? `hp`-`DAMAGE` : 0 (saturating at 0).
    - Pulse `hit` and `ball_clear`; set `spent`; `knockback_dir` <= `ball_face`.
    - If `hp` <= `DAMAGE`, go to KO.
    - Otherwise go to INVULN with counter <= `INVULN_FRAMES`-1.
  - **INVULN:**
    - Overlap is ignored: no damage, no pulses, `spent` unchanged. The projectile passes through.
    - Counter decrements each frame. In the frame where the counter is 0, go to ALIVE.
  - **KO:** `hp`=0. Hits are ignored. Hold until `round_start`.
- `round_start`, in any state, overrides everything else in that frame:
  - Go to ALIVE with `hp`=`MAX_HP` and counter=0.
  - Clear `spent`, `knockback_dir`, `hit` and `ball_clear`.
- `Reset` does the same as `round_start` and has priority over it.

## Timing
- Every output is a register. Reset values:
  - `ball_clear`=0, `hit`=0, `knockback_dir`=0, `invuln`=0, `ko`=0
  - `target_hp`=`MAX_HP`
- Latency: inputs sampled at edge N produce `hit`/`ball_clear` high for exactly the cycle after edge N.
  - `target_hp`, `invuln` and `ko` update at the same edge N.
- A non-fatal hit at edge N gives `invuln`=1 after edges N through N+`INVULN_FRAMES`-1 and `invuln`=0 after edge N+`INVULN_FRAMES`.
- The projectile stage despawns one frame after `ball_clear`. `spent` stops repeat hits during that frame.
- A new projectile needs at least one frame with `summoned_ball`=0 before it can hit.
- Simultaneous fatal hit and `round_start`: `round_start` wins. No pulse; HP = `MAX_HP`.

## Test plan
- **Reset and idle:** Reset, no projectile -> `target_hp`=100, all flags 0 for 100 frames.
- **Single hit, one per flight:**
  - Stimulus: ball (50,100), target (60,90), `summoned_ball` held 1 for 40 frames.
  - Required: exactly one `hit` and one `ball_clear` pulse, `target_hp`=90, `invuln` high for 30 frames, no second hit when INVULN ends.
- **Edge-touch boundary:**
  - Ball x=20 (right edge 36), target x=36: no hit.
  - Ball x=21: hit.
  - Ball at x=1015 with target at x=0: no wrap-induced hit.
- **Re-arm:**
  - Stimulus: hit, then `summoned_ball`=0 for one frame, then a new overlapping flight after INVULN ends.
  - Required: second hit, `target_hp`=80.
- **KO and saturation:** with `DAMAGE`=30, 4 spaced hits -> HP 70, 40, 10, 0; `ko`=1; a fifth overlap gives no pulse.
- **Round restart:** `round_start` during KO, during INVULN, and in the same frame as a hit -> ALIVE, HP=100, `invuln`=0, no pulses.

Source files
------------

// File: rtl/ball_hit_resolver.sv
// ball_hit_resolver: checks the live projectile against the target hitbox once
// per frame. It applies at most one hit per projectile flight and tracks the
// target's HP, its invulnerability window and its knock-out state.
module ball_hit_resolver #(
    parameter int BALL_W        = 16,
    parameter int BALL_H        = 16,
    parameter int TGT_W         = 40,
    parameter int TGT_H         = 80,
    parameter int DAMAGE        = 10,
    parameter int MAX_HP        = 100,
    parameter int INVULN_FRAMES = 30
) (
    input  logic       frame_clk,
    input  logic       Reset,
    input  logic       summoned_ball,
    input  logic [9:0] ball_x,
    input  logic [9:0] ball_y,
    input  logic       ball_face,
    input  logic [9:0] target_x,
    input  logic [9:0] target_y,
    input  logic       round_start,
    output logic       ball_clear,
    output logic       hit,
    output logic       knockback_dir,
    output logic [6:0] target_hp,
    output logic       invuln,
    output logic       ko
);

    typedef enum logic [1:0] {
        ALIVE  = 2'd0,
        INVULN = 2'd1,
        KO     = 2'd2
    } state_t;

    localparam logic [10:0] BALL_W11 = 11'(BALL_W);
    localparam logic [10:0] BALL_H11 = 11'(BALL_H);
    localparam logic [10:0] TGT_W11  = 11'(TGT_W);
    localparam logic [10:0] TGT_H11  = 11'(TGT_H);
    localparam logic [6:0]  DMG7     = 7'(DAMAGE);
    localparam logic [6:0]  HP7      = 7'(MAX_HP);
    localparam logic [5:0]  INV_LOAD = 6'(INVULN_FRAMES - 1);

    state_t      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic        spent_q, spent_d;
    logic [6:0]  hp_d;
    logic        hit_d, clear_d, kb_d;

    // Coordinates widened by one bit so that box edges beyond pixel 1023 don't wrap.
    logic [10:0] bx11, by11, tx11, ty11;
    logic        overlap, candidate;

    assign bx11 = {1'b0, ball_x};
    assign by11 = {1'b0, ball_y};
    assign tx11 = {1'b0, target_x};
    assign ty11 = {1'b0, target_y};

    // Strict comparisons: boxes that only share an edge do not overlap.
    assign overlap = (bx11 < tx11 + TGT_W11) && (tx11 < bx11 + BALL_W11) &&
                     (by11 < ty11 + TGT_H11) && (ty11 < by11 + BALL_H11);

    assign candidate = summoned_ball && !spent_q && overlap;

    // Next-state, HP, invulnerability counter and hit-pulse decode.
    always_comb begin
        // NOTE: every variable gets a default first, so no path leaves one unassigned and no latch is inferred.
        state_d = state_q;
        hp_d    = target_hp;
        cnt_d   = cnt_q;
        spent_d = spent_q;
        hit_d   = 1'b0;
        clear_d = 1'b0;
        kb_d    = knockback_dir;

        // A frame with no projectile re-arms hit detection for the next flight.
        if (!summoned_ball) begin
            spent_d = 1'b0;
        end

        if (round_start) begin
            state_d = ALIVE;
            hp_d    = HP7;
            cnt_d   = 6'd0;
            spent_d = 1'b0;
            kb_d    = 1'b0;
        end else begin
            case (state_q)
                ALIVE: begin
                    if (candidate) begin
                        hit_d   = 1'b1;
                        clear_d = 1'b1;
                        spent_d = 1'b1;
                        kb_d    = ball_face;
                        if (target_hp > DMG7) begin
                            hp_d    = target_hp - DMG7;
                            state_d = INVULN;
                            cnt_d   = INV_LOAD;
                        end else begin
                            hp_d    = 7'd0;
                            state_d = KO;
                        end
                    end
                end
                INVULN: begin
                    // The projectile passes through; the window closes in the frame the counter is 0.
                    if (cnt_q == 6'd0) begin
                        state_d = ALIVE;
                    end else begin
                        cnt_d = cnt_q - 6'd1;
                    end
                end
                KO: begin
                    hp_d = 7'd0;
                end
                default: begin
                    state_d = ALIVE;
                end
            endcase
        end
    end

    // State and registered outputs; Reset restores the round-start condition.
    always_ff @(posedge frame_clk) begin
        // NOTE: sequential state uses non-blocking assignments, so every register samples pre-edge values.
        if (Reset) begin
            state_q       <= ALIVE;
            target_hp     <= HP7;
            cnt_q         <= 6'd0;
            spent_q       <= 1'b0;
            hit           <= 1'b0;
            ball_clear    <= 1'b0;
            knockback_dir <= 1'b0;
            invuln        <= 1'b0;
            ko            <= 1'b0;
        end else begin
            state_q       <= state_d;
            target_hp     <= hp_d;
            cnt_q         <= cnt_d;
            spent_q       <= spent_d;
            hit           <= hit_d;
            ball_clear    <= clear_d;
            knockback_dir <= kb_d;
            invuln        <= (state_d == INVULN);
            ko            <= (state_d == KO);
        end
    end

endmodule

// File: tb/tb_ball_hit_resolver.sv
// Testbench for ball_hit_resolver. Two instances share one stimulus: the
// default one, and a DAMAGE=30 one used for the knock-out sequences.
module tb_ball_hit_resolver;

    logic       frame_clk;
    logic       Reset;
    logic       summoned_ball;
    logic [9:0] ball_x, ball_y, target_x, target_y;
    logic       ball_face;
    logic       round_start;

    logic       ball_clear, hit, knockback_dir, invuln, ko;
    logic [6:0] target_hp;
    logic       k_ball_clear, k_hit, k_knockback_dir, k_invuln, k_ko;
    logic [6:0] k_target_hp;

    ball_hit_resolver dut (
        .frame_clk(frame_clk), .Reset(Reset), .summoned_ball(summoned_ball),
        .ball_x(ball_x), .ball_y(ball_y), .ball_face(ball_face),
        .target_x(target_x), .target_y(target_y), .round_start(round_start),
        .ball_clear(ball_clear), .hit(hit), .knockback_dir(knockback_dir),
        .target_hp(target_hp), .invuln(invuln), .ko(ko)
    );

    ball_hit_resolver #(.DAMAGE(30)) dut_k (
        .frame_clk(frame_clk), .Reset(Reset), .summoned_ball(summoned_ball),
        .ball_x(ball_x), .ball_y(ball_y), .ball_face(ball_face),
        .target_x(target_x), .target_y(target_y), .round_start(round_start),
        .ball_clear(k_ball_clear), .hit(k_hit), .knockback_dir(k_knockback_dir),
        .target_hp(k_target_hp), .invuln(k_invuln), .ko(k_ko)
    );

    initial frame_clk = 1'b0;
    always #5 frame_clk = ~frame_clk;

    typedef struct {
        logic       hit;
        logic       clr;
        logic       kb;
        logic [6:0] hp;
        logic       inv;
        logic       ko;
    } exp_t;

    typedef struct {
        logic       rst;
        logic       rs;
        logic       sb;
        logic       face;
        logic [9:0] bx;
        logic [9:0] by;
        logic [9:0] tx;
        logic [9:0] ty;
        exp_t       e;
    } vec_t;

    exp_t sb_q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    function automatic exp_t mk_exp(logic h, logic c, logic kb, logic [6:0] hp, logic inv, logic k);
        exp_t e;
        e.hit = h; e.clr = c; e.kb = kb; e.hp = hp; e.inv = inv; e.ko = k;
        return e;
    endfunction

    function automatic vec_t mk_vec(logic rst, logic rs, logic sb, logic face,
                                    logic [9:0] bx, logic [9:0] by,
                                    logic [9:0] tx, logic [9:0] ty, exp_t e);
        vec_t v;
        v.rst = rst; v.rs = rs; v.sb = sb; v.face = face;
        v.bx = bx; v.by = by; v.tx = tx; v.ty = ty; v.e = e;
        return v;
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Drive one frame, queue its expected outputs, then pop and compare after the edge.
    task automatic apply(input vec_t v, input bit use_k, input string name);
        exp_t e;
        Reset         = v.rst;
        round_start   = v.rs;
        summoned_ball = v.sb;
        ball_face     = v.face;
        ball_x        = v.bx;
        ball_y        = v.by;
        target_x      = v.tx;
        target_y      = v.ty;
        sb_q.push_back(v.e);
        @(posedge frame_clk);
        #1;
        e = sb_q.pop_front();
        if (use_k) begin
            check({name, ".hit"}, 8'(k_hit), 8'(e.hit));
            check({name, ".clr"}, 8'(k_ball_clear), 8'(e.clr));
            check({name, ".kb"},  8'(k_knockback_dir), 8'(e.kb));
            check({name, ".hp"},  8'(k_target_hp), 8'(e.hp));
            check({name, ".inv"}, 8'(k_invuln), 8'(e.inv));
            check({name, ".ko"},  8'(k_ko), 8'(e.ko));
        end else begin
            check({name, ".hit"}, 8'(hit), 8'(e.hit));
            check({name, ".clr"}, 8'(ball_clear), 8'(e.clr));
            check({name, ".kb"},  8'(knockback_dir), 8'(e.kb));
            check({name, ".hp"},  8'(target_hp), 8'(e.hp));
            check({name, ".inv"}, 8'(invuln), 8'(e.inv));
            check({name, ".ko"},  8'(ko), 8'(e.ko));
        end
    endtask

    // Spaced hits on the DAMAGE=30 instance, each followed by a full invulnerability window.
    task automatic ko_hits(input int n, input string tag);
        logic [6:0] hp_tab [4];
        logic       f;
        hp_tab = '{7'd70, 7'd40, 7'd10, 7'd0};
        for (int k = 0; k < n; k++) begin
            f = ((k % 2) == 1);
            apply(mk_vec(0, 0, 1, f, 50, 100, 60, 90,
                         mk_exp(1, 1, f, hp_tab[k], k < 3, k == 3)),
                  1, $sformatf("%s.hit%0d", tag, k));
            if (k < 3) begin
                for (int j = 1; j <= 30; j++) begin
                    apply(mk_vec(0, 0, 0, 0, 50, 100, 60, 90,
                                 mk_exp(0, 0, f, hp_tab[k], j < 30, 0)),
                          1, $sformatf("%s.wait%0d_%0d", tag, k, j));
                end
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t tbl [9];
        exp_t idle;
        int   n_hit, n_clr;

        idle = mk_exp(0, 0, 0, 100, 0, 0);

        // Boundary table on the default instance; ball 16x16, target 40x80.
        tbl[0] = mk_vec(0, 0, 1, 0, 20,   100, 36,   90, idle);                       // x edges touch
        tbl[1] = mk_vec(0, 0, 1, 0, 1015, 100, 0,    90, idle);                       // no wrap at right edge
        tbl[2] = mk_vec(0, 0, 1, 0, 50,   74,  60,   90, idle);                       // ball bottom touches target top
        tbl[3] = mk_vec(0, 0, 1, 0, 50,   170, 60,   90, idle);                       // ball top touches target bottom
        tbl[4] = mk_vec(0, 0, 1, 1, 21,   100, 36,   90, mk_exp(1, 1, 1, 90, 1, 0));  // one pixel of overlap
        tbl[5] = mk_vec(0, 1, 1, 0, 21,   100, 36,   90, idle);                       // round_start during INVULN
        tbl[6] = mk_vec(0, 0, 1, 0, 1015, 100, 1000, 90, mk_exp(1, 1, 0, 90, 1, 0));  // overlap past pixel 1023
        tbl[7] = mk_vec(0, 0, 1, 0, 1015, 100, 1000, 90, mk_exp(0, 0, 0, 90, 1, 0));  // ignored while INVULN
        tbl[8] = mk_vec(0, 1, 0, 0, 0,    0,   60,   90, idle);

        // Reset state, then 100 idle frames.
        apply(mk_vec(1, 0, 0, 0, 0, 0, 60, 90, idle), 0, "reset0");
        apply(mk_vec(1, 0, 0, 0, 0, 0, 60, 90, idle), 1, "reset1");
        for (int i = 0; i < 100; i++) begin
            apply(mk_vec(0, 0, 0, 0, 50, 100, 60, 90, idle), 0, $sformatf("idle[%0d]", i));
        end

        for (int i = 0; i < 9; i++) begin
            apply(tbl[i], 0, $sformatf("tbl[%0d]", i));
        end

        // One flight held for 40 frames: exactly one hit.
        n_hit = 0;
        n_clr = 0;
        for (int i = 0; i < 40; i++) begin
            apply(mk_vec(0, 0, 1, 0, 50, 100, 60, 90,
                         mk_exp(i == 0, i == 0, 0, 90, i < 30, 0)),
                  0, $sformatf("single[%0d]", i));
            n_hit += int'(hit);
            n_clr += int'(ball_clear);
        end
        check("single.hit_count", 8'(n_hit), 8'd1);
        check("single.clear_count", 8'(n_clr), 8'd1);

        // Re-arm after a gap frame; a re-armed projectile still overlapping hits as INVULN ends.
        apply(mk_vec(0, 0, 0, 0, 50, 100, 60, 90, mk_exp(0, 0, 0, 90, 0, 0)), 0, "rearm.gap");
        apply(mk_vec(0, 0, 1, 1, 50, 100, 60, 90, mk_exp(1, 1, 1, 80, 1, 0)), 0, "rearm.hit");
        apply(mk_vec(0, 0, 0, 0, 50, 100, 60, 90, mk_exp(0, 0, 1, 80, 1, 0)), 0, "rearm.inv_gap");
        for (int i = 2; i < 30; i++) begin
            apply(mk_vec(0, 0, 1, 0, 50, 100, 60, 90, mk_exp(0, 0, 1, 80, 1, 0)),
                  0, $sformatf("rearm.inv[%0d]", i));
        end
        apply(mk_vec(0, 0, 1, 0, 50, 100, 60, 90, mk_exp(0, 0, 1, 80, 0, 0)), 0, "rearm.exit");
        apply(mk_vec(0, 0, 1, 0, 50, 100, 60, 90, mk_exp(1, 1, 0, 70, 1, 0)), 0, "rearm.exit_hit");
        apply(mk_vec(0, 1, 0, 0, 50, 100, 60, 90, idle), 0, "rearm.restart");

        // Knock-out and saturation on the DAMAGE=30 instance.
        apply(mk_vec(0, 1, 0, 0, 50, 100, 60, 90, idle), 1, "ko.restart");
        ko_hits(4, "ko");
        apply(mk_vec(0, 0, 0, 0, 50, 100, 60, 90, mk_exp(0, 0, 1, 0, 0, 1)), 1, "ko.gap");
        for (int i = 0; i < 3; i++) begin
            apply(mk_vec(0, 0, 1, 0, 50, 100, 60, 90, mk_exp(0, 0, 1, 0, 0, 1)),
                  1, $sformatf("ko.fifth[%0d]", i));
        end
        apply(mk_vec(0, 1, 1, 0, 50, 100, 60, 90, idle), 1, "ko.round_start");
        apply(mk_vec(0, 0, 0, 0, 50, 100, 60, 90, idle), 1, "ko.after");

        // round_start in the same frame as a fatal hit wins; the flight is re-armed.
        ko_hits(3, "fatal");
        apply(mk_vec(0, 1, 1, 1, 50, 100, 60, 90, idle), 1, "fatal.rs_same_frame");
        apply(mk_vec(0, 0, 1, 0, 50, 100, 60, 90, mk_exp(1, 1, 0, 70, 1, 0)), 1, "fatal.next_hit");

        // Reset beats a simultaneous candidate.
        apply(mk_vec(1, 0, 1, 1, 50, 100, 60, 90, idle), 1, "reset_prio.k");
        apply(mk_vec(1, 0, 1, 1, 50, 100, 60, 90, idle), 0, "reset_prio");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
